llc_snoop_responder: RTL and testbench
======================================

Name: llc_snoop_responder

Overview:
- Responder side of the shared-bus snoop protocol for the last-level cache.
- Accepts one snooped bus operation (READ, WRITE, INVALIDATE, RWIM) issued by another cache and looks up the line in the LLC tag/MESI store.
- Returns the snoop result (HIT/HITM/NOHIT) and, when the protocol requires it, sends L2-to-L1 messages, issues a modified-line writeback and updates the line's MESI state.
- Sits between the bus model and the LLC tag array, alongside the processor-side request controller.

Parameters:
- WAYS, 16, associativity; width of the way index is $clog2(WAYS).
- ADDRESS_WIDTH, 32, bus address width.
- OFFSET_BITS, 6, line offset bits (64-byte lines).
- INDEX_BITS, 14, set index bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- snp_valid  in  1  snoop request valid.
- snp_ready  out  1  responder idle, can accept a request.
- snp_op  in  3  bus op: 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM.
- snp_addr  in  ADDRESS_WIDTH  snooped address.
- lk_req  out  1  tag lookup request.
- lk_index  out  INDEX_BITS  set index, snp_addr[OFFSET_BITS +: INDEX_BITS].
- lk_addr  out  ADDRESS_WIDTH  line-aligned address; the tag store compares tags.
- lk_ack  in  1  lookup result valid.
- lk_hit  in  1  a valid way matched.
- lk_way  in  $clog2(WAYS)  matching way.
- lk_mesi  in  2  MESI of matching way (I=00, E=01, M=10, S=11).
- l1_valid  out  1  L2-to-L1 message valid.
- l1_msg  out  3  GETLINE=1, INVALIDATELINE=3.
- l1_addr  out  ADDRESS_WIDTH  line-aligned address.
- l1_ready  in  1  L1 accepts the message.
- wb_valid  out  1  writeback (bus WRITE) request valid.
- wb_addr  out  ADDRESS_WIDTH  line-aligned address.
- wb_ready  in  1  bus accepts the writeback.
- upd_valid  out  1  one-cycle MESI write strobe.
- upd_index  out  INDEX_BITS  set to update.
- upd_way  out  $clog2(WAYS)  way to update.
- upd_mesi  out  2  new MESI state.
- res_valid  out  1  one-cycle snoop result strobe.
- res_snoop  out  2  HIT=00, HITM=01, NOHIT=11.
- proto_err  out  1  one-cycle pulse, asserted together with res_valid.

Behaviour:
- Reset (asynchronous, at any time including mid-operation): FSM goes to IDLE and in-flight work is dropped with no update. All strobes/valids are 0, snp_ready=1, res_snoop=NOHIT, and address/index/way/mesi/msg outputs are 0.
- Handshake:
  - A request is accepted when snp_valid & snp_ready. Op and line-aligned address (offset bits zeroed) are registered.
  - snp_ready is high only in IDLE.
  - l1_valid and wb_valid are held with stable payload until their ready is sampled high.
- States: IDLE, LOOKUP, GETL, WB, INV, UPD, RESP.
  - IDLE: on accept of a legal op, go to LOOKUP. An illegal op (0, 5-7) goes directly to RESP with NOHIT and proto_err.
  - LOOKUP: lk_req=1, held until lk_ack. lk_ack may arrive in the first LOOKUP cycle. lk_hit=0 is treated as MESI I.
  - Next state after lookup, first applicable: GETL if MESI=M; else INV if an L1 invalidate is needed; else UPD if the state changes; else RESP.
  - GETL: l1_msg=GETLINE, then go to WB.
  - WB: wb_valid=1, then INV if needed, else UPD.
  - INV: l1_msg=INVALIDATELINE, then UPD.
  - UPD: single-cycle upd_valid, then RESP.
  - RESP: single-cycle res_valid, then IDLE.
- Per-op action table (old MESI -> result, new MESI, L1 invalidate needed):
  - READ: I -> NOHIT, unchanged, no. E -> HIT, S, no. S -> HIT, S (no update), no. M -> HITM, S, no.
  - RWIM: I -> NOHIT, no. E/S -> HIT, I, yes. M -> HITM, I, yes.
  - INVALIDATE: I -> NOHIT, no. S -> HIT, I, yes. E/M -> HIT, unchanged, no, proto_err=1.
  - WRITE: I -> NOHIT, no. Any other state -> NOHIT, unchanged, no, proto_err=1.
- Latency (request accepted in cycle T, lk_ack in the first LOOKUP cycle, all readys high):
  - NOHIT: res_valid at T+2, snp_ready at T+3.
  - READ hit on E: upd_valid at T+2, res_valid at T+3.
  - RWIM hit on M: GETL T+2, WB T+3, INV T+4, UPD T+5, RESP T+6.
- Stalls: l1_ready or wb_ready low holds the current state. Back-pressure never drops or reorders messages.

Test Plan:
- Reset mid-WB (wb_ready=0, wb_valid=1), assert rst -> wb_valid=0, snp_ready=1 immediately. Next request behaves normally.
- READ 0x0000_1040, miss -> res_snoop=11 at T+2, no l1/wb/upd activity, lk_index=0x0041.
- READ 0x1234_5678, hit way 5 in E -> upd_index=0x1159, upd_way=5, upd_mesi=11, then res_snoop=00.
- RWIM hit way 3 in M, l1_ready low 3 cycles -> GETLINE held with l1_addr=0x1234_5640. Then wb_addr=0x1234_5640, INVALIDATELINE, upd_mesi=00, res_snoop=01.
- INVALIDATE hit on E -> res_snoop=00, proto_err=1, no upd_valid, no l1 message.
- snp_op=6 -> res_snoop=11 and proto_err=1 at T+1, lk_req never asserted.

Source files
------------

// File: rtl/llc_snoop_responder_if.sv
// rtl/llc_snoop_responder_if.sv - snoop request, tag lookup, L1 message, writeback, MESI update and result channels
interface llc_snoop_responder_if #(
  parameter int WAYS          = 16,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = 14
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                     snp_valid;
  logic                     snp_ready;
  logic [2:0]               snp_op;
  logic [ADDRESS_WIDTH-1:0] snp_addr;

  logic                     lk_req;
  logic [INDEX_BITS-1:0]    lk_index;
  logic [ADDRESS_WIDTH-1:0] lk_addr;
  logic                     lk_ack;
  logic                     lk_hit;
  logic [WAY_BITS-1:0]      lk_way;
  logic [1:0]               lk_mesi;

  logic                     l1_valid;
  logic [2:0]               l1_msg;
  logic [ADDRESS_WIDTH-1:0] l1_addr;
  logic                     l1_ready;

  logic                     wb_valid;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic                     wb_ready;

  logic                     upd_valid;
  logic [INDEX_BITS-1:0]    upd_index;
  logic [WAY_BITS-1:0]      upd_way;
  logic [1:0]               upd_mesi;

  logic                     res_valid;
  logic [1:0]               res_snoop;
  logic                     proto_err;

  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_mesi, l1_ready, wb_ready,
    output snp_ready, lk_req, lk_index, lk_addr, l1_valid, l1_msg, l1_addr, wb_valid, wb_addr,
           upd_valid, upd_index, upd_way, upd_mesi, res_valid, res_snoop, proto_err
  );

  modport master (
    output snp_valid, snp_op, snp_addr, lk_ack, lk_hit, lk_way, lk_mesi, l1_ready, wb_ready,
    input  snp_ready, lk_req, lk_index, lk_addr, l1_valid, l1_msg, l1_addr, wb_valid, wb_addr,
           upd_valid, upd_index, upd_way, upd_mesi, res_valid, res_snoop, proto_err
  );
endinterface

// File: rtl/llc_snoop_responder.sv
// rtl/llc_snoop_responder.sv - LLC snoop responder: lookup, GETLINE/writeback/invalidate, MESI update, snoop result
module llc_snoop_responder #(
  parameter int WAYS          = 16,
  parameter int ADDRESS_WIDTH = 32,
  parameter int OFFSET_BITS   = 6,
  parameter int INDEX_BITS    = 14
) (
  input logic                 clk,
  input logic                 rst,
  llc_snoop_responder_if.slave bus
);
  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_M = 2'b10;
  localparam logic [1:0] MESI_S = 2'b11;

  localparam logic [1:0] SNP_HIT   = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b01;
  localparam logic [1:0] SNP_NOHIT = 2'b11;

  localparam logic [2:0] MSG_GETLINE = 3'd1;
  localparam logic [2:0] MSG_INVLINE = 3'd3;

  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOOKUP, GETL, WB, INV, UPD, RESP} state_t;

  state_t                   state;
  logic [2:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] line_q;
  logic                     inv_q;
  logic                     perr_q;
  logic [WAY_BITS-1:0]      way_q;
  logic [1:0]               mesi_new_q;

  logic [ADDRESS_WIDTH-1:0] line_addr;
  logic                     op_legal;
  logic [1:0]               old_mesi;
  logic [1:0]               new_mesi;
  logic [1:0]               snoop;
  logic                     need_inv;
  logic                     err;

  assign line_addr = bus.snp_addr & LINE_MASK;
  assign op_legal  = (bus.snp_op >= OP_READ) && (bus.snp_op <= OP_RWIM);

  // Protocol action for the looked-up line; a lookup miss behaves as MESI I.
  always_comb begin
    old_mesi = bus.lk_hit ? bus.lk_mesi : MESI_I;
    new_mesi = old_mesi;
    snoop    = SNP_NOHIT;
    need_inv = 1'b0;
    err      = 1'b0;
    if (old_mesi != MESI_I) begin
      case (op_q)
        OP_READ: begin
          new_mesi = MESI_S;
          snoop    = (old_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
        end
        OP_RWIM: begin
          new_mesi = MESI_I;
          need_inv = 1'b1;
          snoop    = (old_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
        end
        OP_INV: begin
          snoop = SNP_HIT;
          if (old_mesi == MESI_S) begin
            new_mesi = MESI_I;
            need_inv = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      line_q        <= '0;
      inv_q         <= 1'b0;
      perr_q        <= 1'b0;
      way_q         <= '0;
      mesi_new_q    <= MESI_I;
      bus.snp_ready <= 1'b1;
      bus.lk_req    <= 1'b0;
      bus.lk_index  <= '0;
      bus.lk_addr   <= '0;
      bus.l1_valid  <= 1'b0;
      bus.l1_msg    <= '0;
      bus.l1_addr   <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_addr   <= '0;
      bus.upd_valid <= 1'b0;
      bus.upd_index <= '0;
      bus.upd_way   <= '0;
      bus.upd_mesi  <= MESI_I;
      bus.res_valid <= 1'b0;
      bus.res_snoop <= SNP_NOHIT;
      bus.proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.snp_valid) begin
          op_q          <= bus.snp_op;
          line_q        <= line_addr;
          bus.snp_ready <= 1'b0;
          if (op_legal) begin
            state        <= LOOKUP;
            bus.lk_req   <= 1'b1;
            bus.lk_index <= bus.snp_addr[OFFSET_BITS +: INDEX_BITS];
            bus.lk_addr  <= line_addr;
          end else begin
            state         <= RESP;
            bus.res_valid <= 1'b1;
            bus.res_snoop <= SNP_NOHIT;
            bus.proto_err <= 1'b1;
          end
        end
        LOOKUP: if (bus.lk_ack) begin
          bus.lk_req    <= 1'b0;
          bus.res_snoop <= snoop;
          perr_q        <= err;
          inv_q         <= need_inv;
          way_q         <= bus.lk_way;
          mesi_new_q    <= new_mesi;
          // A modified line is always pulled from L1 and written back first, whatever the op.
          if (old_mesi == MESI_M) begin
            state        <= GETL;
            bus.l1_valid <= 1'b1;
            bus.l1_msg   <= MSG_GETLINE;
            bus.l1_addr  <= line_q;
          end else if (need_inv) begin
            state        <= INV;
            bus.l1_valid <= 1'b1;
            bus.l1_msg   <= MSG_INVLINE;
            bus.l1_addr  <= line_q;
          end else if (new_mesi != old_mesi) begin
            state         <= UPD;
            bus.upd_valid <= 1'b1;
            bus.upd_index <= bus.lk_index;
            bus.upd_way   <= bus.lk_way;
            bus.upd_mesi  <= new_mesi;
          end else begin
            state         <= RESP;
            bus.res_valid <= 1'b1;
            bus.proto_err <= err;
          end
        end
        GETL: if (bus.l1_ready) begin
          state        <= WB;
          bus.l1_valid <= 1'b0;
          bus.wb_valid <= 1'b1;
          bus.wb_addr  <= line_q;
        end
        WB: if (bus.wb_ready) begin
          bus.wb_valid <= 1'b0;
          if (inv_q) begin
            state        <= INV;
            bus.l1_valid <= 1'b1;
            bus.l1_msg   <= MSG_INVLINE;
            bus.l1_addr  <= line_q;
          end else begin
            state         <= UPD;
            bus.upd_valid <= 1'b1;
            bus.upd_index <= bus.lk_index;
            bus.upd_way   <= way_q;
            bus.upd_mesi  <= mesi_new_q;
          end
        end
        INV: if (bus.l1_ready) begin
          state         <= UPD;
          bus.l1_valid  <= 1'b0;
          bus.upd_valid <= 1'b1;
          bus.upd_index <= bus.lk_index;
          bus.upd_way   <= way_q;
          bus.upd_mesi  <= mesi_new_q;
        end
        UPD: begin
          state         <= RESP;
          bus.upd_valid <= 1'b0;
          bus.res_valid <= 1'b1;
          bus.proto_err <= perr_q;
        end
        RESP: begin
          state         <= IDLE;
          bus.res_valid <= 1'b0;
          bus.proto_err <= 1'b0;
          bus.snp_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb/tb_llc_snoop_responder.sv - table-driven, hand-sequenced and randomized checks for llc_snoop_responder
module tb_llc_snoop_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_snoop_responder_if bus ();
  llc_snoop_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic        hit;
    logic [3:0]  way;
    logic [1:0]  mesi;
    int          ack_dly;
    int          l1_stall;
    int          wb_stall;
  } stim_t;

  typedef struct {
    logic [1:0] snoop;
    logic       perr;
    logic       upd;
    logic [1:0] upd_mesi;
    logic       getl;
    logic       inv;
    int         res_cyc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: protocol rules per op and old state, latency as a sum of phase lengths.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [1:0] old;
    logic legal;
    old = s.hit ? s.mesi : 2'd0;
    legal = (s.op >= 3'd1) && (s.op <= 3'd4);
    e.snoop = 2'd3;
    e.perr = !legal;
    e.upd_mesi = old;
    e.inv = 1'b0;
    if (legal && old != 2'd0) begin
      case (s.op)
        3'd1: begin e.snoop = (old == 2'd2) ? 2'd1 : 2'd0; e.upd_mesi = 2'd3; end
        3'd4: begin e.snoop = (old == 2'd2) ? 2'd1 : 2'd0; e.upd_mesi = 2'd0; e.inv = 1'b1; end
        3'd3: begin
          e.snoop = 2'd0;
          if (old == 2'd3) begin e.upd_mesi = 2'd0; e.inv = 1'b1; end
          else e.perr = 1'b1;
        end
        default: e.perr = 1'b1;
      endcase
    end
    e.getl = legal && (old == 2'd2);
    e.upd = legal && ((e.upd_mesi != old) || e.getl);
    if (!legal) e.res_cyc = 1;
    else e.res_cyc = 2 + s.ack_dly + (e.getl ? 2 + s.l1_stall + s.wb_stall : 0)
                     + (e.inv ? 1 + s.l1_stall : 0) + (e.upd ? 1 : 0);
    return e;
  endfunction

  task automatic idle_inputs();
    bus.snp_valid = 1'b0; bus.snp_op = '0; bus.snp_addr = '0;
    bus.lk_ack = 1'b0; bus.lk_hit = 1'b0; bus.lk_way = '0; bus.lk_mesi = '0;
    bus.l1_ready = 1'b1; bus.wb_ready = 1'b1;
  endtask

  task automatic run(input stim_t s, input exp_t e, input string tag);
    logic [31:0] line;
    logic [2:0] l1_exp [2];
    int n_l1_exp, l1_i, l1_cnt, wb_n, wb_cnt, upd_n, lk_cnt, c, w;
    bit done, saw_lk, legal;
    line = {s.addr[31:6], 6'd0};
    legal = (s.op >= 3'd1) && (s.op <= 3'd4);
    n_l1_exp = 0; l1_i = 0; l1_cnt = 0; wb_n = 0; wb_cnt = 0; upd_n = 0; lk_cnt = 0;
    done = 0; saw_lk = 0;
    l1_exp[0] = 3'd0; l1_exp[1] = 3'd0;
    if (e.getl) begin l1_exp[n_l1_exp] = 3'd1; n_l1_exp++; end
    if (e.inv) begin l1_exp[n_l1_exp] = 3'd3; n_l1_exp++; end

    @(negedge clk);
    w = 0;
    while (bus.snp_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk({tag, " snp_ready before request"}, bus.snp_ready, 1);
    bus.snp_valid = 1'b1; bus.snp_op = s.op; bus.snp_addr = s.addr;
    @(posedge clk); #1;
    bus.snp_valid = 1'b0; bus.snp_op = 3'($urandom); bus.snp_addr = $urandom;
    c = 1;
    while (!done && c <= 300) begin
      bus.lk_ack = 1'b0; bus.lk_hit = 1'b0; bus.lk_way = '0; bus.lk_mesi = '0;
      if (bus.lk_req) begin
        if (lk_cnt == s.ack_dly) begin
          bus.lk_ack = 1'b1; bus.lk_hit = s.hit; bus.lk_way = s.way; bus.lk_mesi = s.mesi;
        end else lk_cnt++;
      end
      bus.l1_ready = !(bus.l1_valid && l1_cnt < s.l1_stall);
      bus.wb_ready = !(bus.wb_valid && wb_cnt < s.wb_stall);
      @(negedge clk);
      if (bus.lk_req) begin
        saw_lk = 1;
        chk({tag, " lk_index"}, bus.lk_index, s.addr[19:6]);
        chk({tag, " lk_addr"}, bus.lk_addr, line);
      end
      if (bus.l1_valid) begin
        chk({tag, " l1_msg"}, bus.l1_msg, (l1_i < n_l1_exp) ? l1_exp[l1_i] : 3'd0);
        chk({tag, " l1_addr"}, bus.l1_addr, line);
        if (bus.l1_ready) begin l1_i++; l1_cnt = 0; end else l1_cnt++;
      end
      if (bus.wb_valid) begin
        chk({tag, " wb_addr"}, bus.wb_addr, line);
        if (bus.wb_ready) begin wb_n++; wb_cnt = 0; end else wb_cnt++;
      end
      if (bus.upd_valid) begin
        upd_n++;
        chk({tag, " upd_index"}, bus.upd_index, s.addr[19:6]);
        chk({tag, " upd_way"}, bus.upd_way, s.way);
        chk({tag, " upd_mesi"}, bus.upd_mesi, e.upd_mesi);
        chk({tag, " upd cycle"}, c, e.res_cyc - 1);
      end
      if (bus.res_valid) begin
        done = 1;
        chk({tag, " res_snoop"}, bus.res_snoop, e.snoop);
        chk({tag, " proto_err"}, bus.proto_err, e.perr);
        chk({tag, " res cycle"}, c, e.res_cyc);
      end
      if (!done) begin @(posedge clk); #1; c++; end
    end
    bus.lk_ack = 1'b0; bus.l1_ready = 1'b1; bus.wb_ready = 1'b1;
    chk({tag, " result seen"}, done, 1);
    chk({tag, " l1 messages"}, l1_i, n_l1_exp);
    chk({tag, " writebacks"}, wb_n, e.getl ? 1 : 0);
    chk({tag, " updates"}, upd_n, e.upd ? 1 : 0);
    chk({tag, " lookup issued"}, saw_lk, legal);
    @(negedge clk);
    chk({tag, " snp_ready after result"}, bus.snp_ready, 1);
    chk({tag, " res_valid single cycle"}, bus.res_valid, 0);
    chk({tag, " proto_err single cycle"}, bus.proto_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    stim_t s;
    idle_inputs();

    #12;
    chk("reset snp_ready", bus.snp_ready, 1);
    chk("reset res_snoop", bus.res_snoop, 2'b11);
    chk("reset lk_req", bus.lk_req, 0);
    chk("reset l1_valid", bus.l1_valid, 0);
    chk("reset wb_valid", bus.wb_valid, 0);
    chk("reset upd_valid", bus.upd_valid, 0);
    chk("reset res_valid", bus.res_valid, 0);
    chk("reset proto_err", bus.proto_err, 0);
    chk("reset lk_addr", bus.lk_addr, 0);
    chk("reset l1_msg", bus.l1_msg, 0);
    chk("reset upd_mesi", bus.upd_mesi, 0);
    @(negedge clk);
    rst = 1'b0;

    // {op, addr, hit, way, mesi, ack_dly, l1_stall, wb_stall}, {snoop, perr, upd, upd_mesi, getl, inv, res_cyc}
    tbl.push_back('{'{3'd1, 32'h0000_1040, 1'b0, 4'd0, 2'd0, 0, 0, 0}, '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2}});
    tbl.push_back('{'{3'd1, 32'h1234_5678, 1'b1, 4'd5, 2'd1, 0, 0, 0}, '{2'd0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 3}});
    tbl.push_back('{'{3'd4, 32'h1234_5678, 1'b1, 4'd3, 2'd2, 0, 3, 0}, '{2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 12}});
    tbl.push_back('{'{3'd3, 32'h0bad_f00d, 1'b1, 4'd2, 2'd1, 0, 0, 0}, '{2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2}});
    tbl.push_back('{'{3'd6, 32'h0000_2000, 1'b1, 4'd1, 2'd2, 0, 0, 0}, '{2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1}});
    tbl.push_back('{'{3'd1, 32'h0000_3fc0, 1'b1, 4'd4, 2'd3, 0, 0, 0}, '{2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2}});
    tbl.push_back('{'{3'd1, 32'hffff_ffff, 1'b1, 4'd9, 2'd2, 0, 0, 0}, '{2'd1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 5}});
    tbl.push_back('{'{3'd4, 32'h8000_0040, 1'b1, 4'd15, 2'd3, 2, 0, 0}, '{2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 6}});
    tbl.push_back('{'{3'd3, 32'h0000_0000, 1'b1, 4'd0, 2'd3, 0, 0, 0}, '{2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4}});
    tbl.push_back('{'{3'd2, 32'h4444_4444, 1'b1, 4'd6, 2'd1, 0, 0, 0}, '{2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2}});
    tbl.push_back('{'{3'd2, 32'h5555_5540, 1'b1, 4'd7, 2'd2, 0, 0, 2}, '{2'd3, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 7}});
    tbl.push_back('{'{3'd0, 32'h6666_6666, 1'b0, 4'd0, 2'd0, 0, 0, 0}, '{2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1}});
    tbl.push_back('{'{3'd4, 32'h7777_7780, 1'b0, 4'd8, 2'd2, 0, 0, 0}, '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2}});
    tbl.push_back('{'{3'd3, 32'h0123_4567, 1'b1, 4'd10, 2'd2, 1, 1, 0}, '{2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 7}});
    tbl.push_back('{'{3'd4, 32'h89ab_cdef, 1'b1, 4'd11, 2'd1, 0, 2, 0}, '{2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 6}});

    foreach (tbl[i]) run(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    // Reset while a writeback is stalled: everything drops at once, then a normal request.
    @(negedge clk);
    bus.snp_valid = 1'b1; bus.snp_op = 3'd4; bus.snp_addr = 32'h0bad_c0c0;
    @(posedge clk); #1;
    bus.snp_valid = 1'b0; bus.wb_ready = 1'b0; bus.l1_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.wb_valid; i++) begin
      bus.lk_ack = bus.lk_req; bus.lk_hit = 1'b1; bus.lk_way = 4'd7; bus.lk_mesi = 2'd2;
      @(posedge clk); #1;
    end
    bus.lk_ack = 1'b0;
    chk("midwb wb_valid reached", bus.wb_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("midwb wb_valid held", bus.wb_valid, 1);
    chk("midwb wb_addr held", bus.wb_addr, 32'h0bad_c0c0);
    #2 rst = 1'b1;
    #1;
    chk("midwb reset wb_valid", bus.wb_valid, 0);
    chk("midwb reset snp_ready", bus.snp_ready, 1);
    chk("midwb reset upd_valid", bus.upd_valid, 0);
    chk("midwb reset res_valid", bus.res_valid, 0);
    chk("midwb reset wb_addr", bus.wb_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    run(tbl[1].s, tbl[1].e, "after_reset");

    for (int i = 0; i < 150; i++) begin
      s.op = 3'($urandom_range(0, 7));
      s.addr = $urandom;
      s.hit = 1'($urandom_range(0, 1));
      s.way = 4'($urandom_range(0, 15));
      s.mesi = 2'($urandom_range(0, 3));
      s.ack_dly = $urandom_range(0, 3);
      s.l1_stall = $urandom_range(0, 2);
      s.wb_stall = $urandom_range(0, 2);
      run(s, model(s), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
